// File: rtl/sensor_hub_pkg.sv
// Shared types and constants for the sensor display hub.
//   conv_state_e : states of the sequential binary-to-BCD converter
//   BCD_MAX      : largest displayable value; larger readings saturate
//   BLANK_BCD    : code shown for a blanked (stale) channel
//   dd_adjust    : double-dabble digit correction (add 3 when >= 5)
package sensor_hub_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_e;

  localparam int unsigned BCD_MAX   = 9999;
  localparam logic [15:0] BLANK_BCD = 16'hFFFF;

  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request, accepted only in IDLE
//   bin        : binary value (already saturated), sampled in LOAD
//   blank      : when set at LOAD, the result is BLANK_BCD
//   busy       : high in LOAD/SHIFT/DONE
//   bcd        : {thousands,hundreds,tens,ones}, held between conversions
//   done       : one-cycle pulse when bcd updates
module bin2bcd_seq
  import sensor_hub_pkg::*;
#(
  parameter int unsigned DW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] bin,
  input  logic          blank,
  output logic          busy,
  output logic [15:0]   bcd,
  output logic          done
);

  localparam int unsigned SRW = DW + 16;
  localparam int unsigned CW  = $clog2(DW + 1);

  conv_state_e    state;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] sr_adj;
  logic [CW-1:0]  cnt;
  logic           blank_q;

  // Digit correction applied to the BCD field before each shift
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < 4; d++) begin
      sr_adj[DW + 4*d +: 4] = dd_adjust(sr[DW + 4*d +: 4]);
    end
  end

  // Converter FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      blank_q <= 1'b0;
      busy    <= 1'b0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          sr      <= SRW'(bin);
          blank_q <= blank;
          cnt     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          sr  <= sr_adj << 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) state <= DONE;
        end
        DONE: begin
          bcd   <= blank_q ? BLANK_BCD : sr[SRW-1 -: 16];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sensor_display_hub.sv
// N-channel sensor aggregator: staggered start pulses, per-channel data
// latches, manual/auto channel selection and BCD conversion of the shown
// channel.
// Optional feature macro: SENSOR_STALE_BLANK_EN (blank channels that have not
// updated for STALE_CYC cycles).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_data      : channel k value at [k*DW +: DW]
//   i_valid     : per-channel one-cycle latch strobe
//   i_sel       : manual channel select (out of range -> channel 0)
//   i_auto      : 1 = auto-rotate, 0 = manual
//   o_start     : per-channel periodic start pulse
//   o_bcd       : BCD of the shown channel
//   o_bcd_valid : one-cycle pulse when o_bcd updates
//   o_ch        : channel currently shown
//   o_busy      : conversion in progress
module sensor_display_hub
  import sensor_hub_pkg::*;
#(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned DW          = 14,
  parameter int unsigned TRIG_PERIOD = 200_000_000,
  parameter int unsigned DWELL       = 300_000_000,
  parameter int unsigned STALE_CYC   = 400_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*DW-1:0]      i_data,
  input  logic [N_CH-1:0]         i_valid,
  input  logic [$clog2(N_CH)-1:0] i_sel,
  input  logic                    i_auto,
  output logic [N_CH-1:0]         o_start,
  output logic [15:0]             o_bcd,
  output logic                    o_bcd_valid,
  output logic [$clog2(N_CH)-1:0] o_ch,
  output logic                    o_busy
);

  localparam int unsigned SW   = $clog2(N_CH);
  localparam int unsigned TW   = $clog2(TRIG_PERIOD);
  localparam int unsigned WW   = $clog2(DWELL + 1);
  localparam int unsigned STEP = TRIG_PERIOD / N_CH;

  if (N_CH < 2 || N_CH > 8 || DW < 1 || DW > 14 || TRIG_PERIOD < N_CH ||
      DWELL < 1 || STALE_CYC < 1) begin : g_param_check
    $error("sensor_display_hub: parameter out of range");
  end

  logic [TW-1:0] trig_cnt;
  logic [DW-1:0] data_q [N_CH];
  logic [WW-1:0] dwell_cnt;
  logic [WW-1:0] dwell_next;
  logic [SW-1:0] ch_next;
  logic          auto_q;
  logic          pending;
  logic          req;
  logic          stale_req;
  logic          blank;
  logic          conv_start;
  logic [DW-1:0] shown;
  logic [DW-1:0] shown_sat;

  // Shared trigger counter; channel k fires at k*STEP so pulses never overlap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_cnt <= '0;
      o_start  <= '0;
    end else begin
      trig_cnt <= (trig_cnt == TW'(TRIG_PERIOD - 1)) ? '0 : trig_cnt + TW'(1);
      for (int k = 0; k < N_CH; k++) begin
        o_start[k] <= (trig_cnt == TW'(k * STEP));
      end
    end
  end

  // Per-channel latest reading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (i_valid[k]) data_q[k] <= i_data[k*DW +: DW];
      end
    end
  end

  // Next shown channel and dwell count; entering auto restarts the dwell
  always_comb begin
    ch_next    = o_ch;
    dwell_next = dwell_cnt;
    if (!i_auto) begin
      ch_next = (32'(i_sel) >= N_CH) ? '0 : i_sel;
    end else if (!auto_q) begin
      dwell_next = '0;
    end else if (dwell_cnt == WW'(DWELL - 1)) begin
      dwell_next = '0;
      ch_next    = (o_ch == SW'(N_CH - 1)) ? '0 : o_ch + SW'(1);
    end else begin
      dwell_next = dwell_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ch      <= '0;
      dwell_cnt <= '0;
      auto_q    <= 1'b0;
    end else begin
      o_ch      <= ch_next;
      dwell_cnt <= dwell_next;
      auto_q    <= i_auto;
    end
  end

`ifdef SENSOR_STALE_BLANK_EN
  localparam int unsigned AW = $clog2(STALE_CYC + 1);
  logic [AW-1:0] age_q [N_CH];

  // Age since last update, saturating at STALE_CYC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) age_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (i_valid[k])                      age_q[k] <= '0;
        else if (age_q[k] != AW'(STALE_CYC)) age_q[k] <= age_q[k] + AW'(1);
      end
    end
  end

  assign blank     = (age_q[o_ch] == AW'(STALE_CYC));
  assign stale_req = (age_q[o_ch] == AW'(STALE_CYC - 1)) && !i_valid[o_ch];
`else
  assign blank     = 1'b0;
  assign stale_req = 1'b0;
`endif

  assign shown     = data_q[o_ch];
  assign shown_sat = (32'(shown) > BCD_MAX) ? DW'(BCD_MAX) : shown;

  // Requests while busy collapse into one pending conversion
  assign req        = (ch_next != o_ch) || i_valid[o_ch] || stale_req;
  assign conv_start = !o_busy && (req || pending);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                pending <= 1'b0;
    else if (o_busy && req) pending <= 1'b1;
    else if (conv_start)    pending <= 1'b0;
  end

  bin2bcd_seq #(.DW(DW)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (shown_sat),
    .blank (blank),
    .busy  (o_busy),
    .bcd   (o_bcd),
    .done  (o_bcd_valid)
  );

endmodule

// File: tb/tb_sensor_display_hub.sv
// Bench for sensor_display_hub: scoreboard of expected BCD results, checked
// on every o_bcd_valid pulse, plus direct checks of triggers, select and reset.
module tb_sensor_display_hub;

  localparam int unsigned N_CH        = 3;
  localparam int unsigned DW          = 14;
  localparam int unsigned TRIG_PERIOD = 90;
  localparam int unsigned DWELL       = 40;
  localparam int unsigned STALE_CYC   = 200;
  localparam int unsigned SW          = $clog2(N_CH);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_CH*DW-1:0] i_data;
  logic [N_CH-1:0]    i_valid;
  logic [SW-1:0]      i_sel;
  logic               i_auto;
  logic [N_CH-1:0]    o_start;
  logic [15:0]        o_bcd;
  logic               o_bcd_valid;
  logic [SW-1:0]      o_ch;
  logic               o_busy;

  logic [15:0] sb_q[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          valid_cnt = 0;
  int unsigned cyc       = 0;

  sensor_display_hub #(
    .N_CH(N_CH), .DW(DW), .TRIG_PERIOD(TRIG_PERIOD), .DWELL(DWELL), .STALE_CYC(STALE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_sel(i_sel),
    .i_auto(i_auto), .o_start(o_start), .o_bcd(o_bcd), .o_bcd_valid(o_bcd_valid),
    .o_ch(o_ch), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every conversion result must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && o_bcd_valid) begin
      valid_cnt++;
      check("sb_has_entry", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) check("sb_bcd", o_bcd, sb_q.pop_front());
    end
  end

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (!o_busy && sb_q.size() == 0) ok = 1'b1;
    end
    check("wait_idle", 32'(ok), 1);
  endtask

  task automatic drive_valid(input int ch, input int unsigned val);
    @(negedge clk);
    i_data[ch*DW +: DW] = DW'(val);
    i_valid = N_CH'(1 << ch);
    @(negedge clk);
    i_valid = '0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t0;
    int unsigned lat;
    int unsigned last;
    int          prev;
    int          nchg;
    int          vc0;
    bit          seen;
    logic [N_CH-1:0] exp_start;

    i_data = '0; i_valid = '0; i_sel = '0; i_auto = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", o_start, 0);
    check("rst_bcd", o_bcd, 0);
    check("rst_bcd_valid", o_bcd_valid, 0);
    check("rst_ch", o_ch, 0);
    check("rst_busy", o_busy, 0);

    // Staggered trigger pulses relative to reset release
    rst = 1'b0;
    for (int i = 0; i < 95; i++) begin
      @(negedge clk);
      exp_start = '0;
      for (int k = 0; k < N_CH; k++)
        if ((i % TRIG_PERIOD) == k * (TRIG_PERIOD / N_CH)) exp_start[k] = 1'b1;
      check("start", o_start, exp_start);
    end

    // Manual select of ch1, then latency of a data update on the shown channel
    @(negedge clk); i_sel = 1; sb_q.push_back(16'h0000);
    wait_idle(60);
    check("ch_sel1", o_ch, 1);
    @(negedge clk);
    i_data[1*DW +: DW] = DW'(1234); i_valid = 3'b010; t0 = cyc;
    sb_q.push_back(16'h1234);
    @(negedge clk); i_valid = '0;
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (o_bcd_valid) begin seen = 1'b1; lat = cyc - t0 - 1; end
      else @(negedge clk);
    end
    check("valid_seen", 32'(seen), 1);
    check("latency", lat, 16);
    check("bcd_1234", o_bcd, 16'h1234);
    wait_idle(40);

    // Unshown channels latch silently; saturation and out-of-range select
    vc0 = valid_cnt;
    drive_valid(2, 15000);
    drive_valid(0, 7);
    repeat (20) @(negedge clk);
    check("unshown_no_conv", 32'(valid_cnt - vc0), 0);
    @(negedge clk); i_sel = 2; sb_q.push_back(16'h9999);
    wait_idle(60);
    check("ch_sel2", o_ch, 2);
    check("bcd_sat", o_bcd, 16'h9999);
    @(negedge clk); i_sel = 3; sb_q.push_back(16'h0007);
    wait_idle(60);
    check("ch_oor", o_ch, 0);
    check("bcd_7", o_bcd, 16'h0007);

    // Auto rotation from ch0: 0 -> 1 -> 2 -> 0, one conversion per change
    vc0 = valid_cnt;
    @(negedge clk); i_auto = 1'b1;
    sb_q.push_back(16'h1234); sb_q.push_back(16'h9999); sb_q.push_back(16'h0007);
    last = cyc + 1; prev = 0; nchg = 0;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (int'(o_ch) != prev) begin
        check("auto_ch", o_ch, 32'((prev + 1) % N_CH));
        check("auto_dwell", cyc - last, DWELL);
        last = cyc; prev = int'(o_ch); nchg++;
      end
    end
    check("auto_changes", 32'(nchg), 3);
    @(negedge clk); i_auto = 1'b0; i_sel = 0;
    wait_idle(60);
    check("auto_valids", 32'(valid_cnt - vc0), 3);

    // Three updates during one conversion -> two results, last value wins
    @(negedge clk); i_sel = 1; sb_q.push_back(16'h1234);
    wait_idle(60);
    vc0 = valid_cnt;
    drive_valid(1, 100); sb_q.push_back(16'h0100);
    @(negedge clk);
    drive_valid(1, 200);
    @(negedge clk);
    drive_valid(1, 300); sb_q.push_back(16'h0300);
    wait_idle(80);
    check("coalesce_valids", 32'(valid_cnt - vc0), 2);
    check("coalesce_final", o_bcd, 16'h0300);

    // Reset during SHIFT with a pending request
    drive_valid(1, 4321);
    repeat (3) @(negedge clk);
    drive_valid(1, 555);
    check("busy_before_rst", o_busy, 1);
    rst = 1'b1; i_sel = 0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_bcd", o_bcd, 0);
    check("rst_mid_valid", o_bcd_valid, 0);
    check("rst_mid_ch", o_ch, 0);
    vc0 = valid_cnt;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("no_pending_after_rst", 32'(valid_cnt - vc0), 0);
    @(negedge clk); i_sel = 2; sb_q.push_back(16'h0000);
    wait_idle(60);
    check("data_cleared", o_bcd, 16'h0000);

`ifdef SENSOR_STALE_BLANK_EN
    sb_q.push_back(16'hFFFF);
    wait_idle(300);
    check("stale_blank", o_bcd, 16'hFFFF);
    drive_valid(2, 42); sb_q.push_back(16'h0042);
    wait_idle(60);
    check("stale_cleared", o_bcd, 16'h0042);
`endif

    check("sb_empty_end", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
